// File: rtl/ysyx_23060124_issue_ctrl_if.sv
// IDU/EXU/WBU/I-cache handshake bundle seen by the issue controller.
// master drives the i_* side (pipeline), slave is the controller.
interface ysyx_23060124_issue_ctrl_if;
  logic       i_id_valid;
  logic [4:0] i_id_rs1;
  logic [4:0] i_id_rs2;
  logic       i_id_rs1_en;
  logic       i_id_rs2_en;
  logic [4:0] i_id_rd;
  logic       i_id_wen;
  logic       i_id_fence_i;
  logic       i_id_csr;
  logic       i_exu_ready;
  logic       i_redirect;
  logic       i_wb_valid;
  logic       i_wb_wen;
  logic [4:0] i_wb_rd;
  logic       i_fencei_done;
  logic       o_issue_valid;
  logic       o_id_ready;
  logic       o_stall;
  logic       o_fencei_req;
  logic       o_busy;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en,
    output i_id_rd, i_id_wen, i_id_fence_i, i_id_csr, i_exu_ready,
    output i_redirect, i_wb_valid, i_wb_wen, i_wb_rd, i_fencei_done,
    input  o_issue_valid, o_id_ready, o_stall, o_fencei_req, o_busy
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en,
    input  i_id_rd, i_id_wen, i_id_fence_i, i_id_csr, i_exu_ready,
    input  i_redirect, i_wb_valid, i_wb_wen, i_wb_rd, i_fencei_done,
    output o_issue_valid, o_id_ready, o_stall, o_fencei_req, o_busy
  );
endinterface

// File: rtl/ysyx_23060124_issue_ctrl.sv
// Scoreboard-based IDU->EXU issue gate with fence.i drain/flush sequencing; zero added latency.
// YSYX_23060124_CSR_SERIAL_EN: CSR ops also drain the pipeline (no I-cache flush) before issuing.
module ysyx_23060124_issue_ctrl #(
  parameter int INFLIGHT_W = 3,
  parameter int SB_W       = 2
) (
  input logic                      clock,
  input logic                      reset,
  ysyx_23060124_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH_IC, S_RESUME} state_t;

  localparam logic [SB_W-1:0]       SB_MAX = '1;
  localparam logic [SB_W-1:0]       SB_ONE = 1;
  localparam logic [INFLIGHT_W-1:0] IF_MAX = '1;
  localparam logic [INFLIGHT_W-1:0] IF_ONE = 1;

  logic [SB_W-1:0]       r_sb [32];
  logic [INFLIGHT_W-1:0] r_inflight;
  state_t                r_state;
  logic                  r_fencei_req;
  logic                  r_busy;
`ifdef YSYX_23060124_CSR_SERIAL_EN
  logic                  r_csr_flag;
`endif

  logic        w_rs1_hz;
  logic        w_rs2_hz;
  logic        w_rd_full;
  logic        w_hazard;
  logic        w_serial;
  logic        w_issue_allowed;
  logic        w_issue_valid;
  logic        w_fire;
  logic        w_inc;
  logic        w_dec;
  logic [31:0] w_inc_vec;
  logic [31:0] w_dec_vec;

  // Entry 0 is never written after reset, so x0 always reads as idle.
  assign w_rs1_hz  = bus.i_id_rs1_en && (bus.i_id_rs1 != 5'd0) && (r_sb[bus.i_id_rs1] != '0);
  assign w_rs2_hz  = bus.i_id_rs2_en && (bus.i_id_rs2 != 5'd0) && (r_sb[bus.i_id_rs2] != '0);
  assign w_rd_full = bus.i_id_wen && (bus.i_id_rd != 5'd0) && (r_sb[bus.i_id_rd] == SB_MAX);
  assign w_hazard  = w_rs1_hz || w_rs2_hz || w_rd_full || (r_inflight == IF_MAX);

`ifdef YSYX_23060124_CSR_SERIAL_EN
  assign w_serial = bus.i_id_fence_i || bus.i_id_csr;
`else
  assign w_serial = bus.i_id_fence_i;
`endif

  always_comb begin
    w_issue_allowed = 1'b0;
    case (r_state)
      S_RUN:    w_issue_allowed = !w_serial;
      S_RESUME: w_issue_allowed = 1'b1;
      default:  w_issue_allowed = 1'b0;
    endcase
  end

  assign w_issue_valid = bus.i_id_valid && !w_hazard && !bus.i_redirect && w_issue_allowed;
  assign w_fire        = w_issue_valid && bus.i_exu_ready;

  assign w_inc     = w_fire && bus.i_id_wen && (bus.i_id_rd != 5'd0);
  assign w_dec     = bus.i_wb_valid && bus.i_wb_wen && (bus.i_wb_rd != 5'd0);
  assign w_inc_vec = w_inc ? (32'd1 << bus.i_id_rd) : 32'd0;
  assign w_dec_vec = w_dec ? (32'd1 << bus.i_wb_rd) : 32'd0;

  assign bus.o_issue_valid = w_issue_valid;
  assign bus.o_id_ready    = w_fire;
  assign bus.o_stall       = bus.i_id_valid && !w_issue_valid;
  assign bus.o_fencei_req  = r_fencei_req;
  assign bus.o_busy        = r_busy;

  // Same-register issue and retire cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_sb[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i])
          r_sb[i] <= r_sb[i] + SB_ONE;
        else if (w_dec_vec[i] && !w_inc_vec[i])
          r_sb[i] <= r_sb[i] - SB_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_inflight <= '0;
    else if (w_fire && !bus.i_wb_valid)
      r_inflight <= r_inflight + IF_ONE;
    else if (bus.i_wb_valid && !w_fire)
      r_inflight <= r_inflight - IF_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_fencei_req <= 1'b0;
      r_busy       <= 1'b0;
`ifdef YSYX_23060124_CSR_SERIAL_EN
      r_csr_flag   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.i_id_valid && bus.i_id_fence_i && !bus.i_redirect) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
`ifdef YSYX_23060124_CSR_SERIAL_EN
          end else if (bus.i_id_valid && bus.i_id_csr && !bus.i_redirect) begin
            r_state    <= S_DRAIN;
            r_busy     <= 1'b1;
            r_csr_flag <= 1'b1;
`endif
          end
        end
        S_DRAIN: begin
          if (bus.i_redirect) begin
            // The serialising instruction was on the wrong path.
            r_state <= S_RUN;
            r_busy  <= 1'b0;
`ifdef YSYX_23060124_CSR_SERIAL_EN
            r_csr_flag <= 1'b0;
`endif
          end else if (r_inflight == '0) begin
`ifdef YSYX_23060124_CSR_SERIAL_EN
            if (r_csr_flag) begin
              r_state <= S_RESUME;
            end else begin
              r_state      <= S_FLUSH_IC;
              r_fencei_req <= 1'b1;
            end
`else
            r_state      <= S_FLUSH_IC;
            r_fencei_req <= 1'b1;
`endif
          end
        end
        S_FLUSH_IC: begin
          if (bus.i_fencei_done) begin
            r_state      <= S_RESUME;
            r_fencei_req <= 1'b0;
          end
        end
        S_RESUME: begin
          if (w_fire || bus.i_redirect) begin
            r_state <= S_RUN;
            r_busy  <= 1'b0;
`ifdef YSYX_23060124_CSR_SERIAL_EN
            r_csr_flag <= 1'b0;
`endif
          end
        end
        default: begin
          r_state      <= S_RUN;
          r_fencei_req <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Counter wrap is a protocol error upstream; flagged here, not guarded.
  a_inflight_underflow: assert property (@(posedge clock) disable iff (reset)
    !(bus.i_wb_valid && !w_fire && (r_inflight == '0)));
  a_inflight_overflow: assert property (@(posedge clock) disable iff (reset)
    !(w_fire && !bus.i_wb_valid && (r_inflight == IF_MAX)));
  a_sb_underflow: assert property (@(posedge clock) disable iff (reset)
    !(w_dec && !w_inc_vec[bus.i_wb_rd] && (r_sb[bus.i_wb_rd] == '0)));
  a_sb_overflow: assert property (@(posedge clock) disable iff (reset)
    !(w_inc && !w_dec_vec[bus.i_id_rd] && (r_sb[bus.i_id_rd] == SB_MAX)));

endmodule

// File: tb/tb_ysyx_23060124_issue_ctrl.sv
// Directed bench for the issue controller: RAW stalls, scoreboard saturation, fence.i sequencing.
// Inputs change and outputs are sampled in the low phase of the clock.
module tb_ysyx_23060124_issue_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_23060124_issue_ctrl_if bus ();

  ysyx_23060124_issue_ctrl #(.INFLIGHT_W(3), .SB_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic outs(input string tag, input logic iv, input logic rdy, input logic st);
    chk({tag, ".issue_valid"}, {31'd0, bus.o_issue_valid}, {31'd0, iv});
    chk({tag, ".id_ready"},    {31'd0, bus.o_id_ready},    {31'd0, rdy});
    chk({tag, ".stall"},       {31'd0, bus.o_stall},       {31'd0, st});
  endtask

  task automatic fsm(input string tag, input logic req, input logic busy);
    chk({tag, ".fencei_req"}, {31'd0, bus.o_fencei_req}, {31'd0, req});
    chk({tag, ".busy"},       {31'd0, bus.o_busy},       {31'd0, busy});
  endtask

  task automatic id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic wen, input logic fi);
    bus.i_id_valid   = v;
    bus.i_id_rs1     = rs1;
    bus.i_id_rs2     = rs2;
    bus.i_id_rs1_en  = 1'b1;
    bus.i_id_rs2_en  = 1'b1;
    bus.i_id_rd      = rd;
    bus.i_id_wen     = wen;
    bus.i_id_fence_i = fi;
    bus.i_id_csr     = 1'b0;
  endtask

  task automatic idle();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic wb(input logic v, input logic wen, input logic [4:0] rd);
    bus.i_wb_valid = v;
    bus.i_wb_wen   = wen;
    bus.i_wb_rd    = rd;
  endtask

  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  initial begin
    idle();
    wb(1'b0, 1'b0, 5'd0);
    bus.i_exu_ready   = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_fencei_done = 1'b0;

    // reset state
    #2;
    outs("rst", 1'b0, 1'b0, 1'b0);
    fsm("rst", 1'b0, 1'b0);
    nxt();
    nxt();
    reset = 1'b0;
    nxt();

    // RAW on x5: stall until retire, issue the cycle after
    id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); #1; outs("t1_addi", 1'b1, 1'b1, 1'b0); nxt();
    id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); #1; outs("t1_raw0", 1'b0, 1'b0, 1'b1); nxt();
    #1; outs("t1_raw1", 1'b0, 1'b0, 1'b1); nxt();
    wb(1'b1, 1'b1, 5'd5); #1; outs("t1_nobypass", 1'b0, 1'b0, 1'b1); nxt();
    wb(1'b0, 1'b0, 5'd0); #1; outs("t1_issue", 1'b1, 1'b1, 1'b0); nxt();
    idle(); wb(1'b1, 1'b1, 5'd6); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // three writes to x7 saturate sb[7]; the fourth waits for a retire
    id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    #1; chk("t2_w1", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    #1; chk("t2_w2", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    #1; chk("t2_w3", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    #1; outs("t2_w4", 1'b0, 1'b0, 1'b1); nxt();
    wb(1'b1, 1'b1, 5'd7); #1; chk("t2_w4_wb", {31'd0, bus.o_issue_valid}, 32'd0); nxt();
    wb(1'b0, 1'b0, 5'd0); #1; outs("t2_w4_go", 1'b1, 1'b1, 1'b0); nxt();
    idle(); wb(1'b1, 1'b1, 5'd7); nxt(); nxt(); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // issue and retire of x9 in one cycle leaves sb[9] at 1
    id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); #1; chk("t3_w1", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    wb(1'b1, 1'b1, 5'd9); #1; chk("t3_same", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    wb(1'b0, 1'b0, 5'd0); id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    #1; outs("t3_rd_stall", 1'b0, 1'b0, 1'b1); nxt();
    wb(1'b1, 1'b1, 5'd9); #1; outs("t3_rd_wb", 1'b0, 1'b0, 1'b1); nxt();
    wb(1'b0, 1'b0, 5'd0); #1; outs("t3_rd_go", 1'b1, 1'b1, 1'b0); nxt();
    idle(); wb(1'b1, 1'b0, 5'd0); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // fence.i with two in flight: drain, flush, resume
    id(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0); #1; chk("t4_i1", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0); #1; chk("t4_i2", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1; outs("t4_fence", 1'b0, 1'b0, 1'b1); fsm("t4_run", 1'b0, 1'b0); nxt();
    wb(1'b1, 1'b1, 5'd10); #1; outs("t4_drain1", 1'b0, 1'b0, 1'b1); fsm("t4_drain1", 1'b0, 1'b1); nxt();
    wb(1'b1, 1'b1, 5'd11); #1; fsm("t4_drain2", 1'b0, 1'b1); nxt();
    wb(1'b0, 1'b0, 5'd0); #1; fsm("t4_drain3", 1'b0, 1'b1); nxt();
    #1; fsm("t4_flush", 1'b1, 1'b1); chk("t4_flush.iv", {31'd0, bus.o_issue_valid}, 32'd0); nxt();
    bus.i_fencei_done = 1'b1; #1; fsm("t4_done", 1'b1, 1'b1); nxt();
    bus.i_fencei_done = 1'b0; #1; fsm("t4_resume", 1'b0, 1'b1); outs("t4_resume", 1'b1, 1'b1, 1'b0); nxt();
    idle(); wb(1'b1, 1'b0, 5'd0); #1; fsm("t4_back", 1'b0, 1'b0); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // redirect while draining a fence.i returns to RUN with no flush
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1; chk("t5_br", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); nxt();
    bus.i_redirect = 1'b1; #1; fsm("t5_redir", 1'b0, 1'b1); outs("t5_redir", 1'b0, 1'b0, 1'b1); nxt();
    bus.i_redirect = 1'b0; idle(); wb(1'b1, 1'b0, 5'd0); #1; fsm("t5_run", 1'b0, 1'b0); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // x0 is never tracked; CSR ops issue like ALU ops in the default build
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); bus.i_exu_ready = 1'b0;
    #1; outs("t6_notready", 1'b1, 1'b0, 1'b0); nxt();
    bus.i_exu_ready = 1'b1;
    #1; chk("t6_x0w1", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    #1; chk("t6_x0w2", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    #1; chk("t6_x0w3", {31'd0, bus.o_issue_valid}, 32'd1); nxt();
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1; outs("t6_x0rd", 1'b1, 1'b1, 1'b0); nxt();
    id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0); bus.i_id_csr = 1'b1;
    #1; outs("t6_csr", 1'b1, 1'b1, 1'b0); fsm("t6_csr", 1'b0, 1'b0); nxt();
    idle(); wb(1'b1, 1'b1, 5'd0); nxt(); nxt(); nxt(); nxt();
    wb(1'b1, 1'b1, 5'd12); nxt();
    wb(1'b0, 1'b0, 5'd0);

    // reset during FLUSH_IC clears every output immediately
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1; fsm("t7_run", 1'b0, 1'b0); nxt();
    #1; fsm("t7_drain", 1'b0, 1'b1); nxt();
    #1; fsm("t7_flush", 1'b1, 1'b1);
    idle(); reset = 1'b1;
    #1; outs("t7_rst", 1'b0, 1'b0, 1'b0); fsm("t7_rst", 1'b0, 1'b0);
    nxt();
    reset = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
